// File: rtl/sub_rr_sched_pkg.sv
// sub_rr_sched_pkg: shared types and helpers for the round-robin subtract scheduler.
// Holds the FSM state enum, stats width and operand slice pack/unpack helpers.
package sub_rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int STAT_W  = 16;

  // Helpers work on a bus wide enough for the largest legal configuration.
  localparam int MAX_W   = 64;
  localparam int MAX_N   = 8;
  localparam int MAX_BUS = MAX_W * MAX_N;

  function automatic logic [MAX_W-1:0] op_mask(
    input int w
  );
    return ~({MAX_W{1'b1}} << w);
  endfunction

  function automatic logic [MAX_W-1:0] op_unpack(
    input logic [MAX_BUS-1:0] bus,
    input int                 idx,
    input int                 w
  );
    return MAX_W'(bus >> (idx * w)) & op_mask(w);
  endfunction

  function automatic logic [MAX_BUS-1:0] op_pack(
    input logic [MAX_BUS-1:0] bus,
    input int                 idx,
    input int                 w,
    input logic [MAX_W-1:0]   val
  );
    logic [MAX_BUS-1:0] clr;
    logic [MAX_BUS-1:0] ins;
    clr = ~(MAX_BUS'(op_mask(w)) << (idx * w));
    ins = MAX_BUS'(val & op_mask(w)) << (idx * w);
    return (bus & clr) | ins;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
// Ports: req (request vector), ptr (search start), grant (one-hot or zero).
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/subtractor.sv
// subtractor: SIZE-bit signed a-b with a full SIZE+1-bit result.
// Ports: a, b (operands), result (sign-extended difference), overflow (no fit in SIZE bits).
module subtractor #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   result,
  output logic            overflow
);

  assign result   = {a[SIZE-1], a} - {b[SIZE-1], b};
  // Top two bits differ exactly when the difference leaves the SIZE-bit range.
  assign overflow = result[SIZE] ^ result[SIZE-1];

endmodule

// File: rtl/sub_rr_sched.sv
// sub_rr_sched: shares one subtractor among NUM_REQ valid/ready requesters, round-robin.
// Ports: clk, rst_n, req_valid/req_ready/req_a/req_b (per requester), rsp_valid/rsp_ready/
// rsp_id/rsp_result/rsp_overflow (single tagged result channel); with SUB_RR_SCHED_STATS_EN
// defined, also op_count and ovf_count (saturating response counters).
module sub_rr_sched
  import sub_rr_sched_pkg::*;
#(
  parameter  int SIZE    = 8,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*SIZE-1:0] req_a,
  input  logic [NUM_REQ*SIZE-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [SIZE:0]           rsp_result,
  output logic                    rsp_overflow
`ifdef SUB_RR_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]       op_count,
  output logic [STAT_W-1:0]       ovf_count
`endif
);

  state_e               state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      tag;
  logic [ID_W-1:0]      gidx;
  logic [ID_W-1:0]      ptr_nxt;
  logic [SIZE-1:0]      op_a;
  logic [SIZE-1:0]      op_b;
  logic [NUM_REQ-1:0]   grant;
  logic [SIZE:0]        sub_result;
  logic                 sub_overflow;
  logic                 hold_done;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(grant)
  );

  // Grant is only offered from IDLE and never while reset is held.
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = ID_W'(i);
    end
  end

  assign ptr_nxt = (int'(gidx) == NUM_REQ - 1) ? '0
                                               : gidx + ID_W'(1);

  subtractor #(
    .SIZE(SIZE)
  ) u_sub (
    .a       (op_a),
    .b       (op_b),
    .result  (sub_result),
    .overflow(sub_overflow)
  );

  assign hold_done = (state == HOLD) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      tag          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            op_a  <= SIZE'(op_unpack(MAX_BUS'(req_a),
                                     int'(gidx), SIZE));
            op_b  <= SIZE'(op_unpack(MAX_BUS'(req_b),
                                     int'(gidx), SIZE));
            tag   <= gidx;
            ptr   <= ptr_nxt;
            state <= CALC;
          end
        end
        CALC: begin
          rsp_result   <= sub_result;
          rsp_overflow <= sub_overflow;
          rsp_id       <= tag;
          rsp_valid    <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef SUB_RR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (hold_done) begin
      if (op_count != '1) op_count <= op_count + STAT_W'(1);
      if (rsp_overflow && ovf_count != '1)
        ovf_count <= ovf_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sub_rr_sched.sv
// tb_sub_rr_sched: directed and randomized checks of sub_rr_sched.
// Reference model: integer round-robin pointer plus signed integer arithmetic.
module tb_sub_rr_sched;
  import sub_rr_sched_pkg::*;

  localparam int SIZE = 8;
  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int BW   = N * SIZE;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [BW-1:0]   req_a;
  logic [BW-1:0]   req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [SIZE:0]   rsp_result;
  logic            rsp_overflow;
`ifdef SUB_RR_SCHED_STATS_EN
  logic [15:0]     op_count;
  logic [15:0]     ovf_count;
`endif

  int  n_checks = 0;
  int  n_errors = 0;
  int  m_ptr    = 0;
  int  m_ops    = 0;
  int  m_ovf    = 0;
  byte a_v[N];
  byte b_v[N];

  sub_rr_sched #(
    .SIZE   (SIZE),
    .NUM_REQ(N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_overflow(rsp_overflow)
`ifdef SUB_RR_SCHED_STATS_EN
    ,
    .op_count    (op_count),
    .ovf_count   (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic load(int i, logic [7:0] a, logic [7:0] b);
    a_v[i] = byte'(a);
    b_v[i] = byte'(b);
    req_a  = BW'(op_pack(MAX_BUS'(req_a), i, SIZE, MAX_W'(a)));
    req_b  = BW'(op_pack(MAX_BUS'(req_b), i, SIZE, MAX_W'(b)));
  endtask

  task automatic stats_check(string tg);
`ifdef SUB_RR_SCHED_STATS_EN
    check({tg, "/op_count"}, 32'(op_count), 32'(m_ops));
    check({tg, "/ovf_count"}, 32'(ovf_count), 32'(m_ovf));
`else
    if (tg.len() < 0) $display("%s", tg);
`endif
  endtask

  // One scheduling slot: present mask, optionally drop bits before the
  // edge, then follow the accepted op through CALC, HOLD and handshake.
  task automatic op(logic [N-1:0] mask, logic [N-1:0] drop,
                    int hold, string tg, output int g);
    int            d;
    logic [SIZE:0] er;
    logic          eo;
    req_valid = mask;
    #1;
    g = pick(mask);
    check({tg, "/ready"}, 32'(req_ready),
          (g < 0) ? 32'd0 : (32'd1 << g));
    if (drop != '0) begin
      req_valid = mask & ~drop;
      #1;
      g = pick(req_valid);
      check({tg, "/ready_drop"}, 32'(req_ready),
            (g < 0) ? 32'd0 : (32'd1 << g));
    end
    if (g < 0) begin
      tick();
      check({tg, "/idle_valid"}, 32'(rsp_valid), 32'd0);
      req_valid = '0;
      return;
    end
    tick();
    m_ptr = (g + 1) % N;
    check({tg, "/calc_ready"}, 32'(req_ready), 32'd0);
    check({tg, "/calc_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    d  = int'(a_v[g]) - int'(b_v[g]);
    er = d[SIZE:0];
    eo = (d > 127) || (d < -128);
    check({tg, "/valid"}, 32'(rsp_valid), 32'd1);
    check({tg, "/id"}, 32'(rsp_id), 32'(g));
    check({tg, "/result"}, 32'(rsp_result), 32'(er));
    check({tg, "/ovf"}, 32'(rsp_overflow), 32'(eo));
    check({tg, "/hold_ready"}, 32'(req_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tg, "/bp_valid"}, 32'(rsp_valid), 32'd1);
      check({tg, "/bp_data"},
            32'({rsp_id, rsp_overflow, rsp_result}),
            32'({IW'(g), eo, er}));
      check({tg, "/bp_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_ops++;
    if (eo) m_ovf++;
    check({tg, "/done_valid"}, 32'(rsp_valid), 32'd0);
    check({tg, "/kept_data"},
          32'({rsp_id, rsp_overflow, rsp_result}),
          32'({IW'(g), eo, er}));
  endtask

  initial begin
    int g;
    logic [N-1:0] mask;
    logic [N-1:0] drop;
    logic [7:0] va;
    logic [7:0] vb;

    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    #2;
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check("rst/valid", 32'(rsp_valid), 32'd0);
    check("rst/id", 32'(rsp_id), 32'd0);
    check("rst/result", 32'(rsp_result), 32'd0);
    check("rst/ovf", 32'(rsp_overflow), 32'd0);
    check("rst/ready", 32'(req_ready), 32'd0);
    stats_check("rst");
    tick();
    tick();
    req_valid = '0;
    rst_n     = 1'b1;
    m_ptr     = 0;

    load(0, 8'h05, 8'h03);
    op(4'b0001, '0, 0, "single", g);
    check("single/grant", 32'(g), 32'd0);
    load(2, 8'h7F, 8'hFF);
    op(4'b0100, '0, 0, "pos_ovf", g);
    check("pos_ovf/grant", 32'(g), 32'd2);
    load(1, 8'h80, 8'h01);
    op(4'b0010, '0, 0, "neg_ovf", g);
    check("neg_ovf/grant", 32'(g), 32'd1);
    stats_check("three_ops");

    load(3, 8'h10, 8'h20);
    op(4'b1000, '0, 10, "backpressure", g);

    load(2, 8'h33, 8'h44);
    req_valid = 4'b0100;
    tick();
    check("midrst/calc_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst/valid", 32'(rsp_valid), 32'd0);
    check("midrst/ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    m_ops = 0;
    m_ovf = 0;
    tick();
    check("midrst/after", 32'(rsp_valid), 32'd0);
    stats_check("midrst");

    for (int i = 0; i < N; i++) load(i, 8'(i * 17), 8'(i * 5 + 1));
    for (int i = 0; i < 5; i++) begin
      op(4'b1111, '0, 0, "fair", g);
      check("fair/order", 32'(g), 32'(i % N));
    end

    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++) begin
        va = 8'($urandom);
        vb = 8'($urandom);
        if ($urandom_range(0, 3) == 0) va = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'h7F;
        if ($urandom_range(0, 3) == 0) vb = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'hFF;
        load(i, va, vb);
      end
      mask = N'($urandom_range(0, 15));
      drop = ($urandom_range(0, 3) == 0) ? (mask & N'($urandom)) : '0;
      op(mask, drop, $urandom_range(0, 3), "rand", g);
    end
    stats_check("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
